// File: rtl/regfile_preloader.sv
// Purpose : Preloads r[FIRST_REG]..r[NUM_REGS-1] through the regfile write port while holding the CPU.
// Latency : start -> cpu_hold/busy one cycle later; one register per accepted beat; done one cycle after the last beat.
// Backpres: in_ready_o drops outside LOAD or while abort_i is high; in_valid_i may stall for any number of cycles.
//
// Ports
//   clock_i       system clock, all state on posedge
//   reset_i       synchronous, active-low reset
//   start_i       request a preload (sampled only in IDLE)
//   abort_i       cancel an in-progress preload (no done pulse)
//   in_valid_i    in_data_i carries the value for the current register
//   in_data_i     value for register idx
//   in_ready_o    beat accepted on posedge when in_valid_i && in_ready_o
//   cpu_rwe_i     processor write enable
//   cpu_rd_i      processor write register
//   cpu_rdata_i   processor write data
//   rf_we_o       regfile write enable
//   rf_rd_o       regfile write register
//   rf_data_o     regfile write data
//   cpu_hold_o    keep processor stalled while high
//   busy_o        high in LOAD and DONE
//   done_o        one-cycle pulse after the last register is written
//   count_o       registers written in the current/last preload (saturating)

module regfile_preloader #(
    parameter int NUM_REGS  = 32,
    parameter int DATA_W    = 32,
    parameter int FIRST_REG = 1,
    localparam int RD_W     = $clog2(NUM_REGS),
    localparam int CNT_W    = 6
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    input  logic              cpu_rwe_i,
    input  logic [RD_W-1:0]   cpu_rd_i,
    input  logic [DATA_W-1:0] cpu_rdata_i,
    output logic              rf_we_o,
    output logic [RD_W-1:0]   rf_rd_o,
    output logic [DATA_W-1:0] rf_data_o,
    output logic              cpu_hold_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  count_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [RD_W-1:0]  FIRST_IDX = RD_W'(FIRST_REG);
    localparam logic [RD_W-1:0]  LAST_IDX  = RD_W'(NUM_REGS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t             state_q, state_d;
    logic [RD_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               hold_q, hold_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               in_ready;
    logic               beat;

    // Abort takes priority over a pending beat so a cancelled preload
    // never writes one more register on its way out.
    assign in_ready = (state_q == ST_LOAD) && !abort_i;
    assign beat     = in_valid_i && in_ready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        count_d = count_q;
        hold_d  = hold_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // start wins over a simultaneous abort here: abort only
                // has meaning once a preload is running.
                if (start_i) begin
                    state_d = ST_LOAD;
                    idx_d   = FIRST_IDX;
                    count_d = '0;
                    hold_d  = 1'b1;
                    busy_d  = 1'b1;
                end
            end

            ST_LOAD: begin
                if (abort_i) begin
                    // count keeps its partial value for inspection.
                    state_d = ST_IDLE;
                    hold_d  = 1'b0;
                    busy_d  = 1'b0;
                end else if (beat) begin
                    count_d = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        // idx parks on the last register instead of wrapping.
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                hold_d  = 1'b0;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                hold_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers (synchronous active-low reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
            idx_q   <= FIRST_IDX;
            count_q <= '0;
            hold_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Write-port mux: preloader owns the port only in LOAD; CPU writes
    // issued then are dropped rather than queued.
    // ------------------------------------------------------------------
    always_comb begin
        if (state_q == ST_LOAD) begin
            rf_we_o   = beat;
            rf_rd_o   = idx_q;
            rf_data_o = in_data_i;
        end else begin
            rf_we_o   = cpu_rwe_i;
            rf_rd_o   = cpu_rd_i;
            rf_data_o = cpu_rdata_i;
        end
    end

    assign in_ready_o = in_ready;
    assign cpu_hold_o = hold_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign count_o    = count_q;

endmodule

// File: tb/tb_regfile_preloader.sv
module tb_regfile_preloader;

    localparam int NR = 32;
    localparam int DW = 32;
    localparam int RW = 5;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          cpu_rwe;
    logic [RW-1:0] cpu_rd;
    logic [DW-1:0] cpu_rdata;
    logic          rf_we;
    logic [RW-1:0] rf_rd;
    logic [DW-1:0] rf_data;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic [5:0]    count;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    regfile_preloader #(.NUM_REGS(NR), .DATA_W(DW), .FIRST_REG(1)) dut (
        .clock_i    (clock),
        .reset_i    (reset),
        .start_i    (start),
        .abort_i    (abort),
        .in_valid_i (in_valid),
        .in_data_i  (in_data),
        .in_ready_o (in_ready),
        .cpu_rwe_i  (cpu_rwe),
        .cpu_rd_i   (cpu_rd),
        .cpu_rdata_i(cpu_rdata),
        .rf_we_o    (rf_we),
        .rf_rd_o    (rf_rd),
        .rf_data_o  (rf_data),
        .cpu_hold_o (cpu_hold),
        .busy_o     (busy),
        .done_o     (done),
        .count_o    (count)
    );

    // Reference regfile fed by the DUT's write port, plus per-register
    // write counters and a done-pulse counter.
    logic [DW-1:0] rf [NR];
    int            wr_cnt [NR];
    int            done_cnt;
    logic          clr;
    logic          rf_init;

    always @(posedge clock) begin
        if (rf_init) begin
            for (int i = 0; i < NR; i++) rf[i] <= 32'hDEAD_0000 + DW'(i);
        end else if (rf_we === 1'b1) begin
            rf[rf_rd] <= rf_data;
        end
        if (clr) begin
            for (int i = 0; i < NR; i++) wr_cnt[i] <= 0;
            done_cnt <= 0;
        end else begin
            if (rf_we === 1'b1) wr_cnt[rf_rd] <= wr_cnt[rf_rd] + 1;
            if (done === 1'b1) done_cnt <= done_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    // Register contents r1..r31 == base+i, each written exactly once, r0 untouched.
    task automatic check_regs(input string tag, input logic [31:0] base);
        int bad;
        bad = 0;
        for (int i = 1; i < NR; i++) begin
            check($sformatf("%s_r%0d", tag, i), rf[i], base + 32'(i));
            if (wr_cnt[i] != 1) bad++;
        end
        check({tag, "_dup_or_missing"}, 32'(bad), 32'd0);
        check({tag, "_r0_writes"}, 32'(wr_cnt[0]), 32'd0);
    endtask

    initial begin
        int beats;
        int c;
        logic v;

        // ---------------- reset with start held high ----------------
        reset = 1'b0; start = 1'b1; abort = 1'b0;
        in_valid = 1'b0; in_data = '0;
        cpu_rwe = 1'b1; cpu_rd = 5'd3; cpu_rdata = 32'hAA;
        rf_init = 1'b1; clr = 1'b1;
        step(); rf_init = 1'b0; #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_pass_we", 32'(rf_we), 32'd1);
        check("rst_pass_rd", 32'(rf_rd), 32'd3);
        check("rst_pass_data", rf_data, 32'hAA);
        step(); #1;
        check("rst2_hold", 32'(cpu_hold), 32'd0);
        check("rst2_busy", 32'(busy), 32'd0);
        check("rst_cpu_write_r3", rf[3], 32'hAA);
        reset = 1'b1; start = 1'b0; cpu_rwe = 1'b0; clr = 1'b0;
        step();

        // ---------------- full back-to-back load, CPU blocked ----------------
        step(); start = 1'b1; clr = 1'b1;
        step(); start = 1'b0; clr = 1'b0;
        cpu_rwe = 1'b1; cpu_rd = 5'd5; cpu_rdata = 32'd99;
        #1;
        check("load_hold", 32'(cpu_hold), 32'd1);
        check("load_busy", 32'(busy), 32'd1);
        check("load_in_ready", 32'(in_ready), 32'd1);
        check("load_cpu_blocked", 32'(rf_we), 32'd0);
        check("load_count0", 32'(count), 32'd0);
        for (int i = 1; i < NR; i++) begin
            step(); in_valid = 1'b1; in_data = 32'h100 + DW'(i); #1;
            check($sformatf("full_rd_%0d", i), 32'(rf_rd), 32'(i));
        end
        step(); in_valid = 1'b0; cpu_rwe = 1'b0; #1;
        check("full_done", 32'(done), 32'd1);
        check("full_count", 32'(count), 32'd31);
        check("full_done_busy", 32'(busy), 32'd1);
        check("full_done_hold", 32'(cpu_hold), 32'd1);
        check("full_done_in_ready", 32'(in_ready), 32'd0);
        step(); #1;
        check("full_after_done", 32'(done), 32'd0);
        check("full_after_hold", 32'(cpu_hold), 32'd0);
        check("full_after_busy", 32'(busy), 32'd0);
        check("full_after_count", 32'(count), 32'd31);
        check("full_done_pulses", 32'(done_cnt), 32'd1);
        check_regs("full", 32'h100);
        cpu_rwe = 1'b1; cpu_rd = 5'd5; cpu_rdata = 32'd99; #1;
        check("idle_pass_we", 32'(rf_we), 32'd1);
        step(); cpu_rwe = 1'b0; #1;
        check("idle_cpu_write_r5", rf[5], 32'd99);

        // ---------------- stalled stream ----------------
        step(); start = 1'b1; clr = 1'b1;
        step(); start = 1'b0; clr = 1'b0;
        cpu_rwe = 1'b1; cpu_rd = 5'd5; cpu_rdata = 32'd99;
        beats = 0; c = 0;
        while (beats < 31 && c < 400) begin
            step();
            v = ((c / 3) % 2) == 0;
            in_valid = v; in_data = 32'h200 + DW'(beats + 1);
            #1;
            if (c < 12 && !v) check($sformatf("stall_gap_we_%0d", c), 32'(rf_we), 32'd0);
            if (v) beats++;
            c++;
        end
        if (beats < 31) check("stall_budget", 32'(beats), 32'd31);
        step(); in_valid = 1'b0; cpu_rwe = 1'b0; #1;
        check("stall_done", 32'(done), 32'd1);
        check("stall_count", 32'(count), 32'd31);
        step(); #1;
        check_regs("stall", 32'h200);

        // ---------------- abort after 10 beats ----------------
        step(); start = 1'b1; clr = 1'b1;
        step(); start = 1'b0; clr = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step(); in_valid = 1'b1; in_data = 32'h300 + DW'(i);
        end
        step(); abort = 1'b1; in_data = 32'h30B; #1;
        check("abort_in_ready", 32'(in_ready), 32'd0);
        check("abort_no_write", 32'(rf_we), 32'd0);
        step(); abort = 1'b0; in_valid = 1'b0; #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_hold", 32'(cpu_hold), 32'd0);
        check("abort_count", 32'(count), 32'd10);
        check("abort_done", 32'(done), 32'd0);
        step(); #1;
        check("abort_no_done_pulse", 32'(done_cnt), 32'd0);
        check("abort_r1", rf[1], 32'h301);
        check("abort_r10", rf[10], 32'h30A);
        check("abort_r11_unchanged", rf[11], 32'h20B);
        check("abort_r11_writes", 32'(wr_cnt[11]), 32'd0);

        // ---------------- start+abort in IDLE, start while busy ----------------
        step(); start = 1'b1; abort = 1'b1;
        step(); start = 1'b0; abort = 1'b0; #1;
        check("start_wins_hold", 32'(cpu_hold), 32'd1);
        for (int i = 1; i <= 2; i++) begin
            step(); in_valid = 1'b1; in_data = 32'h600 + DW'(i);
        end
        step(); start = 1'b1; in_data = 32'h603; #1;
        check("start_ignored_rd", 32'(rf_rd), 32'd3);
        step(); start = 1'b0; abort = 1'b1; in_valid = 1'b0;
        step(); abort = 1'b0; #1;
        check("start_ignored_count", 32'(count), 32'd3);
        check("start_ignored_busy", 32'(busy), 32'd0);

        // ---------------- reset mid-LOAD, then reload ----------------
        step(); start = 1'b1;
        step(); start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step(); in_valid = 1'b1; in_data = 32'h400 + DW'(i);
        end
        step(); reset = 1'b0; in_data = 32'h405;
        step(); reset = 1'b1; in_valid = 1'b0; #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_hold", 32'(cpu_hold), 32'd0);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        step(); start = 1'b1; clr = 1'b1;
        step(); start = 1'b0; clr = 1'b0;
        step(); in_valid = 1'b1; in_data = 32'h501; #1;
        check("reload_first_rd", 32'(rf_rd), 32'd1);
        for (int i = 2; i < NR; i++) begin
            step(); in_valid = 1'b1; in_data = 32'h500 + DW'(i);
        end
        step(); in_valid = 1'b0; #1;
        check("reload_done", 32'(done), 32'd1);
        check("reload_count", 32'(count), 32'd31);
        step(); #1;
        check_regs("reload", 32'h500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
